sp_bw_dp_ram: RTL and testbench
===============================

# sp_bw_dp_ram

Simple dual-port synchronous RAM with one write port and one read port on a single clock. It generalises the single-port sync RAM with per-byte write enables, a selectable read-during-write policy, an optional output pipeline register and a read-valid strobe. It is the standard storage primitive for FIFOs, line buffers and register-file style blocks that need a concurrent read and write every cycle.

## Interface
- data_width, 32: word width in bits; must be an integer multiple of byte_width.
- byte_width, 8: bits per write-enable lane; lanes = data_width/byte_width.
- addr_width, 8: address bits on both ports.
- ram_depth, 1<<addr_width: number of words; may be less than 2^addr_width.
- rdw_mode, 0: read-during-write policy. 0 = read-old; 1 = write-first, with byte-wise forwarding.
- out_reg, 0: 1 adds an output register stage (read latency 2); 0 gives latency 1.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  addr_width  write address.
- wr_be  in  data_width/byte_width  byte-lane enables; bit i covers wr_data[i*byte_width +: byte_width].
- wr_data  in  data_width  write data.
- rd_en  in  1  read request.
- rd_addr  in  addr_width  read address.
- rd_data  out  data_width  read data; holds its value between reads.
- rd_valid  out  1  one-cycle strobe marking new rd_data.

## Operation
- Memory array storage width is data_width.
- Memory contents are not initialised and are not cleared by rst.
- **Write:** on posedge, if wr_en && !rst && wr_addr < ram_depth, write each lane i with wr_be[i]=1. Lanes with wr_be[i]=0 keep their value.
- wr_en with wr_be all zero is a legal no-op.
- A write to wr_addr >= ram_depth is dropped silently.
- **Read:** on posedge, if rd_en && !rst, capture mem[rd_addr] into the read stage.
- A read with rd_addr >= ram_depth returns all zeros and still raises rd_valid.
- **Collision** (rd_en && wr_en && rd_addr == wr_addr, same edge):
  - rdw_mode=0: returns the pre-write word.
  - rdw_mode=1: returns the merged word. Lanes with wr_be=1 take wr_data; the other lanes take the old contents.
  - A collision with wr_be=0 returns the old word in both modes.
- Non-colliding simultaneous read and write are fully independent.
- **Output stage:**
  - out_reg=0: rd_data and rd_valid come directly from the read stage.
  - out_reg=1: one further register stage. rd_data updates only when the read-stage valid is set; rd_valid is delayed one cycle.
- **Reset:** while rst=1, the read-stage valid, rd_valid and rd_data are forced to 0, and writes are suppressed.
  - Reads issued in the cycle rst asserts are lost.
  - Reads already in the pipeline are flushed; no rd_valid appears after reset for them.
- rd_data is never driven to X after reset until a read of an unwritten location.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, internal read-stage data and valid = 0.
- Read latency from the rd_en edge to rd_data/rd_valid:
  - 1 cycle with out_reg=0.
  - 2 cycles with out_reg=1.
- Throughput is one read and one write per cycle; there is no back-pressure.
- rd_valid is high for exactly one cycle per accepted read. Back-to-back reads give continuous rd_valid.
- A write at edge N is visible to a non-colliding read issued at edge N+1 or later.
- With rdw_mode=1, a colliding read at edge N sees it. With rdw_mode=0, it does not.
- First edge with rst=0 accepts reads and writes normally.

## Test plan
- **Reset:** hold rst 2 cycles with rd_en=1 and wr_en=1 → rd_valid=0 and rd_data=0 throughout. After release, reading the address written during reset returns its prior contents, not the reset-cycle wr_data.
- **Byte lanes:** write 0xAABBCCDD to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101. Read addr 5 → 0xAA22CC44, with rd_valid one cycle (out_reg=0) or two cycles (out_reg=1) after rd_en.
- **Collision:** addr 3 holds 0x00000000. Same-edge write 0xFFFFFFFF with be=4'b0011 and read of addr 3:
  - rdw_mode=0 → 0x00000000.
  - rdw_mode=1 → 0x0000FFFF.
  - A read on the following cycle returns 0x0000FFFF in both modes.
- **Streaming:** write addr 0..255 with data = addr*3, then read 0..255 back-to-back → rd_valid high for 256 consecutive cycles with matching data. With out_reg=1 it is high for the same 256 cycles, shifted by one.
- **Out of range:** with ram_depth=200, write 0xDEADBEEF to addr 210 → dropped. Read addr 210 → 0x0, rd_valid=1. Read addr 199 after writing it → the correct data.
- **Mid-stream reset:** with out_reg=1, issue reads at cycles 0–3 and assert rst at cycle 2 → rd_valid only for the cycle-0 read; rd_data=0 during reset; none for the cycle 1–3 reads.

Source files
------------

// File: rtl/sp_bw_dp_ram_if.sv
// Bus bundle for the simple dual-port RAM: one byte-enabled write port and one read port.
// The master drives requests; the slave (the RAM) returns read data and its valid strobe.
interface sp_bw_dp_ram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [LANES-1:0]      wr_be;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;

   modport master (
      output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid
   );

   modport slave (
      input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/sp_bw_dp_ram.sv
// Single-clock simple dual-port RAM with byte-lane writes, selectable read-during-write policy,
// read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); one read and one write per cycle, no back-pressure.
module sp_bw_dp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int RDW_MODE   = 0,
   parameter int OUT_REG    = 0
) (
   input  logic           i_clk,
   input  logic           i_rst,
   sp_bw_dp_ram_if.slave  io_ram
);
   localparam int                  LANES   = DATA_WIDTH / BYTE_WIDTH;
   localparam int                  IDX_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

   logic                  w_wr_ok;
   logic                  w_rd_inrange;
   logic                  w_fwd;
   logic [IDX_W-1:0]      w_wr_idx;
   logic [IDX_W-1:0]      w_rd_idx;
   logic [DATA_WIDTH-1:0] w_rd_word;

   logic                  r_rd_vld;
   logic [DATA_WIDTH-1:0] r_rd_dat;

   assign w_wr_ok      = io_ram.wr_en && !i_rst && ({1'b0, io_ram.wr_addr} < DEPTH_W);
   assign w_rd_inrange = {1'b0, io_ram.rd_addr} < DEPTH_W;
   assign w_wr_idx     = io_ram.wr_addr[IDX_W-1:0];
   assign w_rd_idx     = io_ram.rd_addr[IDX_W-1:0];
   assign w_fwd        = (RDW_MODE != 0) && io_ram.wr_en && w_rd_inrange &&
                         (io_ram.wr_addr == io_ram.rd_addr);

   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         for (int i = 0; i < LANES; i++) begin
            if (io_ram.wr_be[i]) begin
               r_mem[w_wr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                  io_ram.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Write-first forwarding overlays only the enabled lanes onto the stored word.
   always_comb begin
      w_rd_word = w_rd_inrange ? r_mem[w_rd_idx] : '0;
      if (w_fwd) begin
         for (int i = 0; i < LANES; i++) begin
            if (io_ram.wr_be[i]) begin
               w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = io_ram.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_vld <= 1'b0;
         r_rd_dat <= '0;
      end else begin
         r_rd_vld <= io_ram.rd_en;
         if (io_ram.rd_en) begin
            r_rd_dat <= w_rd_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                  r_out_vld;
         logic [DATA_WIDTH-1:0] r_out_dat;

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_out_vld <= 1'b0;
               r_out_dat <= '0;
            end else begin
               r_out_vld <= r_rd_vld;
               if (r_rd_vld) begin
                  r_out_dat <= r_rd_dat;
               end
            end
         end

         assign io_ram.rd_data  = r_out_dat;
         assign io_ram.rd_valid = r_out_vld;
      end else begin : g_noreg
         assign io_ram.rd_data  = r_rd_dat;
         assign io_ram.rd_valid = r_rd_vld;
      end
   endgenerate
endmodule

// File: tb/tb_sp_bw_dp_ram.sv
// Drives two RAM configurations (read-old/no out reg/256 deep and write-first/out reg/200 deep)
// with identical stimulus and compares both against an array-plus-delay-queue reference.
module tb_sp_bw_dp_ram;
   localparam int DEPTH_A = 256;
   localparam int DEPTH_B = 200;
   localparam int LAT_A   = 1;
   localparam int LAT_B   = 2;

   typedef struct {
      int          due;
      logic [31:0] d;
   } pend_t;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [7:0]  rd_addr;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [31:0] mem_a [DEPTH_A];
   logic [31:0] mem_b [DEPTH_A];
   pend_t       q_a[$];
   pend_t       q_b[$];
   logic        ea_v, eb_v;
   logic [31:0] ea_d, eb_d;

   sp_bw_dp_ram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8)) if_a ();
   sp_bw_dp_ram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8)) if_b ();

   assign if_a.wr_en   = wr_en;
   assign if_a.wr_addr = wr_addr;
   assign if_a.wr_be   = wr_be;
   assign if_a.wr_data = wr_data;
   assign if_a.rd_en   = rd_en;
   assign if_a.rd_addr = rd_addr;
   assign if_b.wr_en   = wr_en;
   assign if_b.wr_addr = wr_addr;
   assign if_b.wr_be   = wr_be;
   assign if_b.wr_data = wr_data;
   assign if_b.rd_en   = rd_en;
   assign if_b.rd_addr = rd_addr;

   sp_bw_dp_ram #(
      .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8),
      .RAM_DEPTH(DEPTH_A), .RDW_MODE(0), .OUT_REG(0)
   ) dut_a (
      .i_clk (clk),
      .i_rst (rst),
      .io_ram(if_a.slave)
   );

   sp_bw_dp_ram #(
      .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8),
      .RAM_DEPTH(DEPTH_B), .RDW_MODE(1), .OUT_REG(1)
   ) dut_b (
      .i_clk (clk),
      .i_rst (rst),
      .io_ram(if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                         input logic [3:0] be);
      logic [31:0] m;
      m = old;
      for (int i = 0; i < 4; i++) if (be[i]) m[i*8 +: 8] = nd[i*8 +: 8];
      return m;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] old, input int depth,
                                              input bit write_first);
      if (int'(rd_addr) >= depth) return 32'h0;
      if (write_first && wr_en && wr_addr == rd_addr) return merge(old, wr_data, wr_be);
      return old;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic drive(input bit we, input logic [7:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input bit re, input logic [7:0] ra);
      wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
   endtask

   // One clock edge: update the reference, then compare both DUTs just after the edge.
   task automatic tick();
      logic [31:0] ra, rb;
      bit          acc;
      acc = rd_en && !rst;
      ra  = model_read(mem_a[rd_addr], DEPTH_A, 1'b0);
      rb  = model_read(mem_b[rd_addr], DEPTH_B, 1'b1);
      @(posedge clk);
      cyc++;
      if (rst) begin
         q_a.delete(); q_b.delete();
         ea_v = 1'b0; ea_d = '0; eb_v = 1'b0; eb_d = '0;
      end else begin
         if (wr_en && int'(wr_addr) < DEPTH_A) mem_a[wr_addr] = merge(mem_a[wr_addr], wr_data, wr_be);
         if (wr_en && int'(wr_addr) < DEPTH_B) mem_b[wr_addr] = merge(mem_b[wr_addr], wr_data, wr_be);
         if (acc) begin
            q_a.push_back('{cyc + LAT_A - 1, ra});
            q_b.push_back('{cyc + LAT_B - 1, rb});
         end
         ea_v = 1'b0;
         if (q_a.size() > 0 && q_a[0].due == cyc) begin
            ea_v = 1'b1; ea_d = q_a[0].d; void'(q_a.pop_front());
         end
         eb_v = 1'b0;
         if (q_b.size() > 0 && q_b[0].due == cyc) begin
            eb_v = 1'b1; eb_d = q_b[0].d; void'(q_b.pop_front());
         end
      end
      #1;
      check("a_vld", {31'b0, if_a.rd_valid}, {31'b0, ea_v});
      check("a_dat", if_a.rd_data, ea_d);
      check("b_vld", {31'b0, if_b.rd_valid}, {31'b0, eb_v});
      check("b_dat", if_b.rd_data, eb_d);
   endtask

   initial begin
      int cnt_a, cnt_b, first_a, first_b;

      ea_v = 1'b0; eb_v = 1'b0; ea_d = '0; eb_d = '0;
      rst = 1'b1;
      drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0);
      tick(); tick();
      rst = 1'b0;

      // Fill the array: addr*3 everywhere.
      for (int i = 0; i < 256; i++) begin
         drive(1, 8'(i), 4'hF, 32'(i * 3), 0, 8'd0);
         tick();
      end

      // Back-to-back streaming read.
      cnt_a = 0; cnt_b = 0; first_a = -1; first_b = -1;
      for (int i = 0; i < 258; i++) begin
         if (i < 256) drive(0, 8'd0, 4'h0, 32'h0, 1, 8'(i));
         else         drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0);
         tick();
         if (if_a.rd_valid) begin cnt_a++; if (first_a < 0) first_a = cyc; end
         if (if_b.rd_valid) begin cnt_b++; if (first_b < 0) first_b = cyc; end
      end
      check("stream_cnt_a", 32'(cnt_a), 32'd256);
      check("stream_cnt_b", 32'(cnt_b), 32'd256);
      check("stream_shift", 32'(first_b - first_a), 32'd1);

      // Reset with requests active: nothing comes out, write is suppressed.
      rst = 1'b1;
      drive(1, 8'd7, 4'hF, 32'h12345678, 1, 8'd7);
      tick();
      check("rst_vld_a", {31'b0, if_a.rd_valid}, 32'd0);
      check("rst_dat_b", if_b.rd_data, 32'd0);
      tick();
      rst = 1'b0;
      drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd7);
      tick();
      check("rst_keep_a", if_a.rd_data, 32'd21);
      drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0);
      tick();
      check("rst_keep_b", if_b.rd_data, 32'd21);

      // Byte lanes.
      drive(1, 8'd5, 4'hF, 32'hAABBCCDD, 0, 8'd0); tick();
      drive(1, 8'd5, 4'b0101, 32'h11223344, 0, 8'd0); tick();
      drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd5); tick();
      check("lane_a", if_a.rd_data, 32'hAA22CC44);
      check("lane_vld_a", {31'b0, if_a.rd_valid}, 32'd1);
      check("lane_vld_b_early", {31'b0, if_b.rd_valid}, 32'd0);
      drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0); tick();
      check("lane_b", if_b.rd_data, 32'hAA22CC44);

      // Collision policies.
      drive(1, 8'd3, 4'hF, 32'h0, 0, 8'd0); tick();
      drive(1, 8'd3, 4'b0011, 32'hFFFFFFFF, 1, 8'd3); tick();
      check("coll_old_a", if_a.rd_data, 32'h00000000);
      drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0); tick();
      check("coll_new_b", if_b.rd_data, 32'h0000FFFF);
      drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd3); tick();
      check("coll_after_a", if_a.rd_data, 32'h0000FFFF);
      drive(1, 8'd3, 4'h0, 32'h55555555, 1, 8'd3); tick();
      check("coll_be0_a", if_a.rd_data, 32'h0000FFFF);
      drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0); tick();
      check("coll_be0_b", if_b.rd_data, 32'h0000FFFF);

      // Out of range on the 200-deep instance.
      drive(1, 8'd210, 4'hF, 32'hDEADBEEF, 0, 8'd0); tick();
      drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd210); tick();
      check("oor_a", if_a.rd_data, 32'hDEADBEEF);
      drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0); tick();
      check("oor_b", if_b.rd_data, 32'h0);
      check("oor_vld_b", {31'b0, if_b.rd_valid}, 32'd1);
      drive(1, 8'd199, 4'hF, 32'hCAFEF00D, 0, 8'd0); tick();
      drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd199); tick();
      drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0); tick();
      check("last_b", if_b.rd_data, 32'hCAFEF00D);

      // Mid-stream reset flushes the pipelined instance.
      cnt_b = 0;
      for (int i = 0; i < 7; i++) begin
         rst = (i == 2 || i == 3);
         if (i < 4) drive(0, 8'd0, 4'h0, 32'h0, 1, 8'(10 + i));
         else       drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0);
         tick();
         if (if_b.rd_valid) cnt_b++;
         if (i == 2) check("mid_rst_dat_b", if_b.rd_data, 32'h0);
      end
      rst = 1'b0;
      check("mid_rst_cnt_b", 32'(cnt_b), 32'd1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 4'($urandom),
               $urandom, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) rd_addr = wr_addr;
         tick();
      end
      rst = 1'b0;
      drive(0, 8'd0, 4'h0, 32'h0, 0, 8'd0);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
